imem_port_arbiter: RTL and testbench

//   Shares the single-ported instruction memory between the CPU fetch stage and the

---
 rtl/imem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_imem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one single-ported instruction RAM between CPU fetch and the loader/debug port.
// Latency: grant drives the memory in the request cycle; the read response is returned exactly one cycle later.
// Backpressure: combinational readies, one grant per cycle; fetch wins unless the loader holds lock or is starved.
module imem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [31:0]       f_addr,
  input  logic              f_flush,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req_valid,
  output logic              l_req_ready,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_rsp_valid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_t;

  owner_t           owner_q, owner_d;
  logic             load_we_q, load_we_d;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_d;
  logic             f_gnt, l_gnt, starved;
  logic             unused_addr_bits;

  // Byte-lane and out-of-range address bits never reach the memory.
  assign unused_addr_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0], l_addr[31:ADDR_W+2], l_addr[1:0]};

  // Loader is owed a slot once fetch has won STARVE_MAX times in a row against it.
  assign starved = l_req_valid && (starve_cnt == CNT_MAX);

  // Arbitration: lock and starvation force the loader, otherwise an unflushed fetch wins.
  // Readies are held low during reset so nothing is accepted while the owner tag is cleared.
  always_comb begin
    f_req_ready = 1'b0;
    l_req_ready = 1'b0;
    if (rst_n) begin
      if (l_lock || starved)
        l_req_ready = 1'b1;
      else if (f_req_valid && !f_flush)
        f_req_ready = 1'b1;
      else
        l_req_ready = 1'b1;
    end
  end

  assign f_gnt = f_req_ready && f_req_valid;
  assign l_gnt = l_req_ready && l_req_valid;

  // Memory port follows the granted requester; idle cycles drive all zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_en   = 1'b1;
      mem_addr = f_addr[ADDR_W+1:2];
    end else if (l_gnt) begin
      mem_en    = 1'b1;
      mem_we    = l_we;
      mem_addr  = l_addr[ADDR_W+1:2];
      mem_wdata = l_wdata;
    end
  end

  // State register: response owner tag and starvation counter; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= OWN_NONE;
      load_we_q  <= 1'b0;
      starve_cnt <= '0;
    end else begin
      owner_q    <= owner_d;
      load_we_q  <= load_we_d;
      starve_cnt <= starve_cnt_d;
    end
  end

  // Next state: tag whoever was granted; count fetch wins only while the loader is waiting.
  always_comb begin
    owner_d      = OWN_NONE;
    load_we_d    = 1'b0;
    starve_cnt_d = starve_cnt;
    if (f_gnt) begin
      owner_d = OWN_FETCH;
    end else if (l_gnt) begin
      owner_d   = OWN_LOAD;
      load_we_d = l_we;
    end
    if (!l_req_valid || l_gnt)
      starve_cnt_d = '0;
    else if (f_gnt && (starve_cnt != CNT_MAX))
      starve_cnt_d = starve_cnt + CNT_W'(1);
  end

  // Response outputs: a redirect in the response cycle kills the fetch data; loader writes ack with zero data.
  always_comb begin
    f_rvalid    = (owner_q == OWN_FETCH) && !f_flush;
    f_rdata     = '0;
    l_rsp_valid = (owner_q == OWN_LOAD);
    l_rdata     = '0;
    if ((owner_q == OWN_FETCH) && !f_flush)
      f_rdata = mem_rdata;
    if ((owner_q == OWN_LOAD) && !load_we_q)
      l_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed and randomized checks of imem_port_arbiter against a transaction-level model.
// Latency: the model predicts memory drive in the request cycle and the response one cycle later.
// Backpressure: the model applies the fetch-priority / lock / starvation grant rule per cycle.
module tb_imem_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int SM     = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              f_req_valid, f_req_ready, f_flush, f_rvalid;
  logic [31:0]       f_addr;
  logic [DATA_W-1:0] f_rdata;
  logic              l_req_valid, l_req_ready, l_we, l_lock, l_rsp_valid;
  logic [31:0]       l_addr;
  logic [DATA_W-1:0] l_wdata, l_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  imem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_addr(f_addr), .f_flush(f_flush),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_we(l_we), .l_addr(l_addr),
    .l_wdata(l_wdata), .l_lock(l_lock), .l_rsp_valid(l_rsp_valid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E37_79B9 + 32'h0000_1357;
  endfunction

  function automatic logic [ADDR_W-1:0] word_of(input logic [31:0] a);
    return ADDR_W'(a >> 2);
  endfunction

  // Single-ported synchronous RAM seen by the DUT, preloaded on the first edge.
  logic [DATA_W-1:0] tmem [DEPTH];
  bit                mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < DEPTH; i++) tmem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) tmem[mem_addr] <= mem_wdata;
      else        mem_rdata      <= tmem[mem_addr];
    end
  end

  // Reference model state: expected memory image, pending response, fetch wins against a waiting loader.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                p_kind;   // 0 none, 1 fetch read, 2 loader read, 3 loader write
  logic [DATA_W-1:0] p_data;
  int                wins;
  bit                e_fr, e_lr, e_en, e_we, e_fv, e_lv;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata, e_fd, e_ld;
  int                e_gnt;    // 0 none, 1 fetch, 2 loader

  task automatic apply(input bit fv, input logic [31:0] fa, input bit fl, input bit lv,
                       input bit lwe, input logic [31:0] la, input logic [31:0] lwd, input bit lk);
    f_req_valid = fv; f_addr = fa; f_flush = fl;
    l_req_valid = lv; l_we = lwe; l_addr = la; l_wdata = lwd; l_lock = lk;
  endtask

  // Predict this cycle's outputs at mid-cycle, then advance the model past the coming edge.
  task automatic eval_model();
    logic [ADDR_W-1:0] w;
    bit fg, lg;
    @(negedge clk);
    e_fv = (p_kind == 1) && !f_flush;
    e_fd = e_fv ? p_data : '0;
    e_lv = (p_kind == 2) || (p_kind == 3);
    e_ld = (p_kind == 2) ? p_data : '0;
    if (l_lock || (l_req_valid && wins >= SM)) begin
      e_fr = 1'b0; e_lr = 1'b1;
    end else if (f_req_valid && !f_flush) begin
      e_fr = 1'b1; e_lr = 1'b0;
    end else begin
      e_fr = 1'b0; e_lr = 1'b1;
    end
    fg = e_fr;
    lg = e_lr && l_req_valid;
    w = fg ? word_of(f_addr) : word_of(l_addr);
    e_en    = fg || lg;
    e_we    = lg && l_we;
    e_addr  = e_en ? w : '0;
    e_wdata = e_we ? l_wdata : '0;
    e_gnt   = fg ? 1 : (lg ? 2 : 0);
    if (fg) begin
      p_kind = 1; p_data = ref_mem[w];
    end else if (lg && l_we) begin
      p_kind = 3; p_data = '0; ref_mem[w] = l_wdata;
    end else if (lg) begin
      p_kind = 2; p_data = ref_mem[w];
    end else begin
      p_kind = 0; p_data = '0;
    end
    if (!l_req_valid || lg) wins = 0;
    else if (fg && wins < SM) wins = wins + 1;
  endtask

  task automatic drive(input bit fv, input logic [31:0] fa, input bit fl, input bit lv,
                       input bit lwe, input logic [31:0] la, input logic [31:0] lwd, input bit lk);
    @(posedge clk); #1;
    apply(fv, fa, fl, lv, lwe, la, lwd, lk);
    eval_model();
  endtask

  function automatic int obs_gnt();
    if (f_req_ready && f_req_valid) return 1;
    if (l_req_ready && l_req_valid) return 2;
    return 0;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    apply(1, 32'h10, 0, 1, 1, 32'h20, 32'hDEAD_BEEF, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    p_kind = 0; p_data = '0; wins = 0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({f_req_ready, l_req_ready, mem_en, mem_we} !== 4'b0)
      $display("FAIL reset_ctrl got %b want 0000", {f_req_ready, l_req_ready, mem_en, mem_we});
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_wdata} !== '0) $display("FAIL reset_mem_bus got %h want 0", {mem_addr, mem_wdata});
    else n_pass++;
    n_checks++;
    if ({f_rvalid, f_rdata, l_rsp_valid, l_rdata} !== '0)
      $display("FAIL reset_rsp got %h want 0", {f_rvalid, f_rdata, l_rsp_valid, l_rdata});
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    eval_model();
    n_checks++;
    if ({f_req_ready, l_req_ready, mem_en} !== {e_fr, e_lr, e_en})
      $display("FAIL reset_release_idle got %b want %b", {f_req_ready, l_req_ready, mem_en}, {e_fr, e_lr, e_en});
    else n_pass++;
  endtask

  task automatic test_fetch_seq();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1, 32'(4 * i), 0, 0, 0, 0, 0, 0);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0);
      if (i < 3) begin
        n_checks++;
        if (!mem_en || mem_we || mem_addr !== ADDR_W'(i))
          $display("FAIL fetch_seq_addr%0d got en=%b we=%b addr=%0d want en=1 we=0 addr=%0d", i, mem_en, mem_we, mem_addr, i);
        else n_pass++;
      end
      if (i > 0) begin
        n_checks++;
        if (f_rvalid !== 1'b1 || f_rdata !== init_word(i - 1))
          $display("FAIL fetch_seq_data%0d got v=%b d=%h want v=1 d=%h", i, f_rvalid, f_rdata, init_word(i - 1));
        else n_pass++;
      end
      n_checks++;
      if (l_rsp_valid !== 1'b0) $display("FAIL fetch_seq_lrsp%0d got %b want 0", i, l_rsp_valid);
      else n_pass++;
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [3];
    logic [ADDR_W-1:0] want [3];
    addrs[0] = 32'h0000_0007; want[0] = 10'd1;
    addrs[1] = 32'h0000_1004; want[1] = 10'd1;
    addrs[2] = 32'hFFFF_F00E; want[2] = 10'd3;
    for (int i = 0; i < 3; i++) begin
      drive(1, addrs[i], 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (mem_addr !== want[i]) $display("FAIL misaligned_%h got %0d want %0d", addrs[i], mem_addr, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    drive(1, 32'h40, 0, 0, 0, 0, 0, 0);
    drive(1, 32'h80, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if ({f_rvalid, f_rdata} !== '0 || f_req_ready !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL flush_drop got rv=%b rd=%h rdy=%b en=%b want 0 0 0 0", f_rvalid, f_rdata, f_req_ready, mem_en);
    else n_pass++;
    drive(1, 32'h44, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (f_rvalid !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 10'd17)
      $display("FAIL flush_refetch got rv=%b en=%b addr=%0d want 0 1 17", f_rvalid, mem_en, mem_addr);
    else n_pass++;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (f_rvalid !== 1'b1 || f_rdata !== init_word(17))
      $display("FAIL flush_refetch_data got v=%b d=%h want 1 %h", f_rvalid, f_rdata, init_word(17));
    else n_pass++;
  endtask

  task automatic test_lock();
    drive(1, 32'h100, 0, 1, 1, 32'h20, 32'h1234_5678, 1);
    n_checks++;
    if (f_req_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 10'd8 || mem_wdata !== 32'h1234_5678)
      $display("FAIL lock_write got rdy=%b we=%b addr=%0d wd=%h want 0 1 8 12345678", f_req_ready, mem_we, mem_addr, mem_wdata);
    else n_pass++;
    drive(1, 32'h104, 0, 1, 0, 32'h20, 32'h0, 1);
    n_checks++;
    if (f_req_ready !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd8)
      $display("FAIL lock_read got rdy=%b en=%b we=%b addr=%0d want 0 1 0 8", f_req_ready, mem_en, mem_we, mem_addr);
    else n_pass++;
    n_checks++;
    if (l_rsp_valid !== 1'b1 || l_rdata !== '0)
      $display("FAIL lock_write_ack got v=%b d=%h want 1 0", l_rsp_valid, l_rdata);
    else n_pass++;
    drive(1, 32'h108, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (f_req_ready !== 1'b0 || l_rsp_valid !== 1'b1 || l_rdata !== 32'h1234_5678 || f_rvalid !== 1'b0)
      $display("FAIL lock_readback got rdy=%b v=%b d=%h frv=%b want 0 1 12345678 0", f_req_ready, l_rsp_valid, l_rdata, f_rvalid);
    else n_pass++;
  endtask

  task automatic test_starvation();
    int wt;
    wt = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      drive(1, $urandom & 32'hFC, 0, 1, 0, $urandom & 32'hFC, 0, 0);
      wt++;
      n_checks++;
      if (obs_gnt() !== ((i % 5 == 4) ? 2 : 1))
        $display("FAIL starve_pattern%0d got %0d want %0d", i, obs_gnt(), (i % 5 == 4) ? 2 : 1);
      else n_pass++;
      if (obs_gnt() == 2) begin
        n_checks++;
        if (wt > 5) $display("FAIL starve_wait got %0d want <=5", wt);
        else n_pass++;
        wt = 0;
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] fa, la;
    for (int i = 0; i < 300; i++) begin
      fa = (32'($urandom_range(0, 31)) << 2) | ($urandom & 32'hFFFF_F003);
      la = (32'($urandom_range(0, 31)) << 2) | ($urandom & 32'hFFFF_F003);
      drive($urandom_range(0, 9) < 7, fa, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, la, $urandom, $urandom_range(0, 9) == 0);
      n_checks++;
      if ({f_req_ready, l_req_ready, mem_en, mem_we, mem_addr} !== {e_fr, e_lr, e_en, e_we, e_addr})
        $display("FAIL rand_port%0d got %b want %b", i, {f_req_ready, l_req_ready, mem_en, mem_we, mem_addr},
                 {e_fr, e_lr, e_en, e_we, e_addr});
      else n_pass++;
      n_checks++;
      if ({f_rvalid, f_rdata, l_rsp_valid, l_rdata} !== {e_fv, e_fd, e_lv, e_ld})
        $display("FAIL rand_rsp%0d got %h want %h", i, {f_rvalid, f_rdata, l_rsp_valid, l_rdata}, {e_fv, e_fd, e_lv, e_ld});
      else n_pass++;
      if (e_we || !e_en) begin
        n_checks++;
        if (mem_wdata !== e_wdata) $display("FAIL rand_wdata%0d got %h want %h", i, mem_wdata, e_wdata);
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 32'h200 + 32'(4 * i), 0, 1, 0, 32'h300, 0, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({f_rvalid, l_rsp_valid, mem_en, f_req_ready, l_req_ready} !== 5'b0)
      $display("FAIL async_reset_outs got %b want 00000", {f_rvalid, l_rsp_valid, mem_en, f_req_ready, l_req_ready});
    else n_pass++;
    p_kind = 0; p_data = '0; wins = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply(1, 32'h210, 0, 1, 0, 32'h304, 0, 0);
    eval_model();
    n_checks++;
    if ({f_rvalid, l_rsp_valid} !== 2'b00) $display("FAIL async_reset_stale got %b want 00", {f_rvalid, l_rsp_valid});
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) drive(1, 32'h210 + 32'(4 * i), 0, 1, 0, 32'h304, 0, 0);
      n_checks++;
      if (obs_gnt() !== ((i == 4) ? 2 : 1))
        $display("FAIL async_reset_starve%0d got %0d want %0d", i, obs_gnt(), (i == 4) ? 2 : 1);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fetch_seq();
    test_misaligned();
    test_flush();
    test_lock();
    test_starvation();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
